ks_multiword_adder_seq: RTL and testbench

//  Sequencer wrapped around the existing 32-bit kogge_stone_adder for multi-precision add/subtract.

---
 rtl/ks_add_pkg.sv | 14 +
 rtl/kogge_stone_adder.sv | 44 ++++
 rtl/ks_multiword_adder_seq.sv | 113 +++++++++++
 tb/tb_ks_multiword_adder_seq.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/ks_add_pkg.sv
// Shared constants and state encodings for the multi-word
// Kogge-Stone add/subtract sequencer.
package ks_add_pkg;

    localparam int WORD_W    = 32;
    localparam int MAX_WORDS = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/kogge_stone_adder.sv
// 32-bit Kogge-Stone parallel-prefix adder with carry-in.
// Carry-in is folded into bit 0 generate so the prefix tree yields all carries.
module kogge_stone_adder
    import ks_add_pkg::*;
(
    input  logic [WORD_W-1:0] A,
    input  logic [WORD_W-1:0] B,
    input  logic              Cin,
    output logic [WORD_W-1:0] sum,
    output logic              Cout
);

    logic [WORD_W-1:0] p0;
    logic [WORD_W-1:0] g;
    logic [WORD_W-1:0] p;
    logic [WORD_W-1:0] g_n;
    logic [WORD_W-1:0] p_n;

    // Log2(32)=5 prefix levels; g[i] ends up as the carry out of bit i.
    always_comb begin
        p0     = A ^ B;
        g      = A & B;
        g[0]   = g[0] | (p0[0] & Cin);
        p      = p0;
        g_n    = g;
        p_n    = p;
        for (int k = 0; k < 5; k++) begin
            g_n = g;
            p_n = p;
            for (int i = 0; i < WORD_W; i++) begin
                if (i >= (1 << k)) begin
                    g_n[i] = g[i] | (p[i] & g[i - (1 << k)]);
                    p_n[i] = p[i] & p[i - (1 << k)];
                end
            end
            g = g_n;
            p = p_n;
        end
    end

    assign sum  = p0 ^ {g[WORD_W-2:0], Cin};
    assign Cout = g[WORD_W-1];

endmodule

// File: rtl/ks_multiword_adder_seq.sv
// Multi-precision add/subtract: streams WORDS 32-bit slices, LSW first,
// through one Kogge-Stone adder, chaining the carry through a register.
module ks_multiword_adder_seq
    import ks_add_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      op_sub,
    input  logic [WORDS*WORD_W-1:0]   A,
    input  logic [WORDS*WORD_W-1:0]   B,
    input  logic                      Cin,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WORDS*WORD_W-1:0]   sum,
    output logic                      Cout
);

    localparam int DW = WORDS * WORD_W;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [DW-1:0]   a_q, a_d;
    logic [DW-1:0]   b_q, b_d;
    logic            carry_q, carry_d;
    logic [DW-1:0]   sum_q, sum_d;
    logic            cout_q, cout_d;

    logic [WORD_W-1:0] add_a;
    logic [WORD_W-1:0] add_b;
    logic [WORD_W-1:0] add_sum;
    logic              add_cout;

    assign add_a = a_q[idx_q*WORD_W +: WORD_W];
    assign add_b = b_q[idx_q*WORD_W +: WORD_W];

    kogge_stone_adder u_add (
        .A    (add_a),
        .B    (add_b),
        .Cin  (carry_q),
        .sum  (add_sum),
        .Cout (add_cout)
    );

    // Next-state: accept (B inverted and carry forced to 1 for subtract),
    // slice-by-slice run, then hold the result until consumed.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = A;
                    b_d     = op_sub ? ~B : B;
                    carry_d = op_sub ? 1'b1 : Cin;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                sum_d[idx_q*WORD_W +: WORD_W] = add_sum;
                carry_d = add_cout;
                if (idx_q == LAST) begin
                    cout_d  = add_cout;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers, cleared by asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE) && !rst;
    assign out_valid = (state_q == ST_DONE);
    assign sum       = sum_q;
    assign Cout      = cout_q;

endmodule

// File: tb/tb_ks_multiword_adder_seq.sv
// Directed bench for the multi-word Kogge-Stone sequencer
// (WORDS=4 main instance, WORDS=1 latency instance).
module tb_ks_multiword_adder_seq;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         op_sub = 1'b0;
    logic [127:0] A = '0;
    logic [127:0] B = '0;
    logic         Cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] sum;
    logic         Cout;

    logic         in_valid1 = 1'b0;
    logic         in_ready1;
    logic [31:0]  A1 = '0;
    logic [31:0]  B1 = '0;
    logic         out_valid1;
    logic         out_ready1 = 1'b0;
    logic [31:0]  sum1;
    logic         Cout1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ks_multiword_adder_seq #(.WORDS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_sub    (op_sub),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .Cout      (Cout)
    );

    ks_multiword_adder_seq #(.WORDS(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .op_sub    (1'b0),
        .A         (A1),
        .B         (B1),
        .Cin       (1'b0),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .sum       (sum1),
        .Cout      (Cout1)
    );

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One transaction on the WORDS=4 instance, with optional backpressure.
    task automatic run_op(input string tag,
                          input logic [127:0] a, input logic [127:0] b,
                          input logic cin, input logic sub,
                          input logic [127:0] es, input logic ec,
                          input int hold);
        int lat;
        logic [127:0] s0;
        logic         c0;
        @(negedge clk);
        A = a; B = b; Cin = cin; op_sub = sub; in_valid = 1'b1;
        check({tag, "_in_ready"}, 128'(in_ready), 128'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        A = ~a; B = ~b; Cin = ~cin; op_sub = ~sub;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!out_valid && lat < 20);
        check({tag, "_latency"}, 128'(lat), 128'd4);
        check({tag, "_sum"}, sum, es);
        check({tag, "_cout"}, 128'(Cout), 128'(ec));
        s0 = sum;
        c0 = Cout;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            A = 128'(i) * 128'h1111; B = 128'(i + 3); op_sub = i[0];
            check({tag, "_bp_sum"}, sum, s0);
            check({tag, "_bp_cout"}, 128'(Cout), 128'(c0));
            check({tag, "_bp_in_ready"}, 128'(in_ready), 128'd0);
            check({tag, "_bp_out_valid"}, 128'(out_valid), 128'd1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_drop_valid"}, 128'(out_valid), 128'd0);
        check({tag, "_ready_again"}, 128'(in_ready), 128'd1);
    endtask

    initial begin
        int lat;
        bit seen;

        // Reset held for 3 cycles
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 128'(in_ready), 128'd0);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_sum", sum, 128'd0);
        check("rst_cout", 128'(Cout), 128'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rel_in_ready", 128'(in_ready), 128'd1);

        // Full ripple
        run_op("ripple", {128{1'b1}}, 128'd1, 1'b0, 1'b0,
               128'd0, 1'b1, 0);

        // Mixed
        run_op("mix1", 128'h1234_5678, 128'h8765_4321, 1'b0, 1'b0,
               128'h9999_9999, 1'b0, 0);
        run_op("mix2", {4{32'hAAAA_AAAA}}, {4{32'h5555_5555}}, 1'b1, 1'b0,
               128'd0, 1'b1, 0);

        // Subtract, Cin ignored
        run_op("sub_neg", 128'd5, 128'd7, 1'b1, 1'b1,
               {{124{1'b1}}, 4'hE}, 1'b0, 0);
        run_op("sub_pos", 128'd7, 128'd5, 1'b1, 1'b1,
               128'd2, 1'b1, 0);

        // Carry crossing a word boundary
        run_op("xword", 128'h0000_0001_FFFF_FFFF_0000_0000, 128'h1_0000_0000,
               1'b0, 1'b0, 128'h0000_0002_0000_0000_0000_0000, 1'b0, 0);

        // Backpressure, then a following op
        run_op("bp", 128'h10, 128'h20, 1'b1, 1'b0, 128'h31, 1'b0, 10);
        run_op("after_bp", 128'd100, 128'd58, 1'b0, 1'b1, 128'd42, 1'b1, 0);

        // Reset in 2nd RUN cycle
        @(negedge clk);
        A = {128{1'b1}}; B = 128'd1; Cin = 1'b0; op_sub = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1; #1;
        check("midrst_valid", 128'(out_valid), 128'd0);
        check("midrst_in_ready", 128'(in_ready), 128'd0);
        check("midrst_sum", sum, 128'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("midrst_never_valid", 128'(seen), 128'd0);
        run_op("post_rst", {128{1'b1}}, 128'd1, 1'b0, 1'b0,
               128'd0, 1'b1, 0);

        // WORDS=1 instance
        @(negedge clk);
        A1 = 32'hFFFF_FFFF; B1 = 32'd1; in_valid1 = 1'b1;
        check("w1_in_ready", 128'(in_ready1), 128'd1);
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!out_valid1 && lat < 20);
        check("w1_latency", 128'(lat), 128'd1);
        check("w1_sum", 128'(sum1), 128'd0);
        check("w1_cout", 128'(Cout1), 128'd1);
        @(negedge clk);
        out_ready1 = 1'b1;
        @(posedge clk); #1;
        out_ready1 = 1'b0;
        check("w1_ready_again", 128'(in_ready1), 128'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
